uart_byte_tx: RTL and testbench

Low-level UART serializer that sits directly downstream of the message-to-byte TX bridge. It accepts one byte at a time over a valid/ready handshake and drives the serial line to the FTDI USB module: 8N1 by default, LSB first, at a fixed baud rate derived from the system clock. Its `ready_out` is the bridge's `ll_ready_in`, and its `byte_in`/`valid_in` are the bridge's `ll_byte_out`/`ll_valid_out`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_byte_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_byte_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the byte-wide UART transmitter.
// Frame state encoding, data width and clocks-per-bit calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int calc_cpb(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick_out in the last clock of each bit.
// clear_in restarts the period so a new frame starts on a clean phase.
module uart_baud_tick #(
  parameter int CPB = 10
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_in,
  output logic tick_out
);

  localparam int W = $clog2(CPB);
  localparam logic [W-1:0] LAST = W'(CPB - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick_out = (cnt_q == LAST);
    cnt_d    = cnt_q + 1'b1;
    if (clear_in || tick_out) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte serializer, LSB first, gapless back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 3_000_000,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int CPB = calc_cpb(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  generate
    if (CPB < 2) begin : g_cpb_bad
      $error("uart_byte_tx: CPB must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_bad
      $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic stop_idx_q, stop_idx_d;
  logic tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  logic tick;
  logic xfer;
  logic last_stop;

  uart_baud_tick #(
    .CPB(CPB)
  ) u_tick (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clear_in(xfer),
    .tick_out(tick)
  );

  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  // Ready also in the final stop cycle so frames run back to back.
  assign ready_out = (state_q == IDLE)
                  || (state_q == STOP && tick && last_stop);
  assign xfer      = valid_in && ready_out;
  assign busy_out  = (state_q != IDLE);
  assign tx_out    = tx_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = START;
          shreg_d    = byte_in;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d      = ^byte_in;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!last_stop) begin
            stop_idx_d = 1'b1;
          end else if (xfer) begin
            state_d    = START;
            shreg_d    = byte_in;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d      = ^byte_in;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is registered from the next state to stay glitch-free.
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at CPB = 10 with a frame scoreboard.
// Honors UART_TX_PARITY_EN for the parity frame length and checks.
module tb_uart_byte_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int EXP_FRAMES = 8;
`else
  localparam int NB = 10;
  localparam int EXP_FRAMES = 6;
`endif
  localparam int FL = NB * CPB;
  localparam int STOP_MID = CPB * (NB - 1) + CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] byte_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       tx_out;
  logic       busy_out;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];

  uart_byte_tx #(
    .CLK_FREQ_HZ(100_000_000),
    .BAUD_RATE  (10_000_000),
    .STOP_BITS  (1)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .byte_in  (byte_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx_out   (tx_out),
    .busy_out (busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Receiver: samples each bit mid-period and scores whole frames.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         n_frames = 0;
  logic [7:0] rx_b = '0;
  logic       rx_par = 1'b0;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx_out === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5)
        rx_b[(rx_cnt - 15) / 10] = tx_out;
      if (rx_cnt == 95) rx_par = tx_out;
      if (rx_cnt == STOP_MID) begin
        rx_on = 1'b0;
        n_frames++;
        chk("rx_stop", tx_out, 1'b1);
        if (sb.size() == 0) begin
          chk("rx_unexpected", rx_b, 32'hdead);
        end else begin
          rx_exp = sb.pop_front();
          chk("rx_byte", rx_b, rx_exp);
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", rx_par, ^rx_exp);
`endif
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in  = b;
    valid_in = 1'b1;
    sb.push_back(b);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      chk(tag, tx_out, fbit(b, (k - 1) / CPB));
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic par_case(input logic [7:0] b, input logic pbit);
    send(b);
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      if (k == 95) chk("par_bit", tx_out, pbit);
      if (k == FL) chk("par_len_busy", busy_out, 1'b1);
    end
    @(negedge clk);
    chk("par_len_idle", busy_out, 1'b0);
  endtask
`endif

  int rdy_hits;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_out, 1'b1);
    chk("rst_busy", busy_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready_out, 1'b1);

    send(8'hA5);
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      chk("a5_line", tx_out, fbit(8'hA5, (k - 1) / CPB));
      if (k == 1) chk("a5_busy_rise", busy_out, 1'b1);
      if (k == FL - 1) chk("a5_rdy_early", ready_out, 1'b0);
      if (k == FL) chk("a5_rdy_last", ready_out, 1'b1);
      if (k == FL) chk("a5_busy_last", busy_out, 1'b1);
    end
    @(negedge clk);
    chk("a5_busy_fall", busy_out, 1'b0);
    chk("a5_idle_tx", tx_out, 1'b1);

    @(negedge clk);
    byte_in  = 8'h00;
    valid_in = 1'b1;
    sb.push_back(8'h00);
    @(posedge clk);
    #1 byte_in = 8'hFF;
    sb.push_back(8'hFF);
    for (int k = 1; k <= 2 * FL; k++) begin
      @(negedge clk);
      if (k <= FL)
        chk("b2b_line0", tx_out, fbit(8'h00, (k - 1) / CPB));
      else
        chk("b2b_line1", tx_out, fbit(8'hFF, (k - FL - 1) / CPB));
      if (k == FL) chk("b2b_rdy", ready_out, 1'b1);
      if (k == FL + 1) begin
        chk("b2b_busy_gapless", busy_out, 1'b1);
        valid_in = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle", busy_out, 1'b0);

    send(8'h55);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      chk("mid_line", tx_out, fbit(8'h55, (k - 1) / CPB));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_out, 1'b1);
    chk("mid_rst_busy", busy_out, 1'b0);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rdy", ready_out, 1'b1);
    chk("mid_tx", tx_out, 1'b1);
    send(8'h3C);
    check_frame(8'h3C, "post_rst_line");

    send(8'h96);
    rdy_hits = 0;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      chk("stall_line", tx_out, fbit(8'h96, (k - 1) / CPB));
      if (k < FL && ready_out) rdy_hits++;
      if (k == FL) begin
        chk("stall_rdy", ready_out, 1'b1);
        byte_in = 8'hC3;
        sb.push_back(8'hC3);
      end else begin
        byte_in = 8'($urandom);
      end
      valid_in = 1'b1;
    end
    chk("stall_no_rdy", rdy_hits, 0);
    @(posedge clk);
    #1 valid_in = 1'b0;
    byte_in = 8'h00;
    check_frame(8'hC3, "stall_next_line");

`ifdef UART_TX_PARITY_EN
    par_case(8'h07, 1'b1);
    par_case(8'hA5, 1'b0);
`endif

    for (int i = 0; i < 4 * FL && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    chk("frame_count", n_frames, EXP_FRAMES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
